// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - UART transmitter that pulls frames from an upstream FIFO
//
// Purpose: reads one word from a first-word-fall-after-read FIFO, then sends
// it as a serial frame: start bit, WIDTH data bits LSB first, optional even
// parity bit, one stop bit. Every bit lasts CLKS_PER_BIT clocks.
//
// Optional feature: define UART_PARITY_EN to insert an even parity bit
// between the last data bit and the stop bit.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   fifo_empty  upstream FIFO empty flag
//   fifo_dout   upstream FIFO read data, valid the cycle after fifo_rd
//   fifo_rd     registered one-cycle read strobe (high only in FETCH)
//   tx          registered serial output, idle high
//   busy        high whenever the transmitter is not idle
//   frame_done  one-cycle pulse on the last clock of the stop bit
module fifo_uart_tx #(
   parameter int WIDTH        = 8,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             fifo_empty,
   input  logic [WIDTH-1:0] fifo_dout,
   output logic             fifo_rd,
   output logic             tx,
   output logic             busy,
   output logic             frame_done
);

   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BIT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LOAD,
      START,
      DATA,
`ifdef UART_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   state_t             state;
   state_t             state_d;
   logic [BAUD_W-1:0]  baud;
   logic [BAUD_W-1:0]  baud_d;
   logic [BIT_W-1:0]   bit_cnt;
   logic [BIT_W-1:0]   bit_d;
   logic [WIDTH-1:0]   shreg;
   logic [WIDTH-1:0]   shreg_d;
   logic               tx_d;
   logic               bit_end;

   // Last clock of the current serial bit.
   assign bit_end = (baud == BAUD_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         baud    <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
         tx      <= 1'b1;
         fifo_rd <= 1'b0;
      end else begin
         state   <= state_d;
         baud    <= baud_d;
         bit_cnt <= bit_d;
         shreg   <= shreg_d;
         tx      <= tx_d;
         // Registered strobe: asserted for exactly the cycle spent in FETCH.
         fifo_rd <= (state_d == FETCH);
      end
   end

   always_comb begin
      state_d = state;
      baud_d  = baud;
      bit_d   = bit_cnt;
      shreg_d = shreg;
      case (state)
         IDLE: begin
            if (!fifo_empty) state_d = FETCH;
         end
         FETCH: begin
            state_d = LOAD;
         end
         LOAD: begin
            // fifo_dout is valid now, one cycle after the read strobe.
            shreg_d = fifo_dout;
            baud_d  = '0;
            state_d = START;
         end
         START: begin
            if (bit_end) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = DATA;
            end else begin
               baud_d = baud + 1'b1;
            end
         end
         DATA: begin
            if (bit_end) begin
               baud_d = '0;
               if (bit_cnt == BIT_LAST) begin
                  bit_d = '0;
`ifdef UART_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end else begin
                  bit_d = bit_cnt + 1'b1;
               end
            end else begin
               baud_d = baud + 1'b1;
            end
         end
`ifdef UART_PARITY_EN
         PARITY: begin
            if (bit_end) begin
               baud_d  = '0;
               state_d = STOP;
            end else begin
               baud_d = baud + 1'b1;
            end
         end
`endif
         STOP: begin
            if (bit_end) begin
               baud_d  = '0;
               state_d = IDLE;
            end else begin
               baud_d = baud + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            baud_d  = '0;
            bit_d   = '0;
         end
      endcase
   end

   // tx is derived from the next state and next bit index, so the registered
   // line only moves when state or bit index moves, i.e. on bit boundaries.
   always_comb begin
      tx_d = 1'b1;
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shreg_d[bit_d];
`ifdef UART_PARITY_EN
         PARITY:  tx_d = ^shreg_d;
`endif
         default: tx_d = 1'b1;
      endcase
   end

   assign busy       = (state != IDLE);
   assign frame_done = (state == STOP) && bit_end;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - scoreboard bench for fifo_uart_tx
module tb_fifo_uart_tx;

   localparam int W = 8;
   localparam int C = 4;
`ifdef UART_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int NB  = 2 + W + P;
   localparam int NS  = NB * C;
   localparam int LAT = 1 + NB * C;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         fifo_empty;
   logic [W-1:0] fifo_dout = '0;
   logic         fifo_rd;
   logic         tx;
   logic         busy;
   logic         frame_done;

   fifo_uart_tx #(.WIDTH(W), .CLKS_PER_BIT(C)) dut (
      .clk        (clk),
      .rst        (rst),
      .fifo_empty (fifo_empty),
      .fifo_dout  (fifo_dout),
      .fifo_rd    (fifo_rd),
      .tx         (tx),
      .busy       (busy),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
   endtask

   // Upstream FIFO model and expected-frame store
   logic [7:0] fifo_mem [0:255];
   logic [7:0] exp_mem  [0:255];
   int         pushed  = 0;
   int         popped  = 0;
   int         exp_wr  = 0;
   int         drop_to = 0;
   logic       tog_en  = 1'b0;
   logic       tog_val = 1'b1;

   assign fifo_empty = tog_en ? tog_val : (pushed == popped);

   always @(posedge clk) begin
      int nw;
      nw = exp_wr;
      if (fifo_rd) begin
         chk("rd_nonempty", pushed != popped, 1);
         if (pushed != popped) begin
            fifo_dout          <= fifo_mem[popped % 256];
            exp_mem[nw % 256]  <= fifo_mem[popped % 256];
            popped             <= popped + 1;
            nw                 = nw + 1;
         end
      end
      exp_wr <= nw;
      // A reset discards every word already read but not yet fully sent.
      if (rst) drop_to <= nw;
   end

   // Monitor: decodes tx, checks frame contents, timing and handshakes
   int            cyc = 0;
   logic          cap = 1'b0;
   int            ns = 0;
   logic [NS-1:0] s_tx, s_busy, s_done;
   int            rd_cyc = 0;
   logic          rd_valid = 1'b0;
   int            done_cyc = 0;
   logic          done_valid = 1'b0;
   logic          idle_ne = 1'b0;
   int            exp_rd = 0;

   task automatic check_frame();
      logic [NB-1:0] bits;
      logic          stable;
      logic [NS-1:0] want_done;
      logic [7:0]    data;
      logic [7:0]    e;
      int            idx;
      stable = 1'b1;
      for (int k = 0; k < NB; k++) begin
         bits[k] = s_tx[k*C];
         for (int j = 1; j < C; j++)
            if (s_tx[k*C+j] !== bits[k]) stable = 1'b0;
      end
      want_done = '0;
      want_done[NS-1] = 1'b1;
      chk("bit_stable", stable, 1);
      chk("busy_frame", &s_busy, 1);
      chk("done_pos", s_done == want_done, 1);
      chk("start_bit", bits[0], 0);
      chk("stop_bit", bits[NB-1], 1);
      data = bits[W:1];
      idx = (exp_rd > drop_to) ? exp_rd : drop_to;
      chk("frame_expected", idx < exp_wr, 1);
      if (idx < exp_wr) begin
         e = exp_mem[idx % 256];
         chk("data", data, e);
`ifdef UART_PARITY_EN
         chk("parity", bits[W+1], ^e);
`endif
         exp_rd = idx + 1;
      end
   endtask

   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         cap        = 1'b0;
         rd_valid   = 1'b0;
         done_valid = 1'b0;
      end else begin
         if (!cap && tx == 1'b0) begin
            cap = 1'b1;
            ns  = 0;
         end
         if (cap) begin
            s_tx[ns]   = tx;
            s_busy[ns] = busy;
            s_done[ns] = frame_done;
            ns++;
            if (ns == NS) begin
               check_frame();
               cap = 1'b0;
            end
         end
         if (frame_done) begin
            chk("done_latency", rd_valid ? (cyc - rd_cyc) : -1, LAT);
            rd_valid   = 1'b0;
            done_valid = 1'b1;
            done_cyc   = cyc;
         end else if (done_valid && cyc == done_cyc + 1) begin
            chk("idle_busy", busy, 0);
            idle_ne = !fifo_empty;
         end else if (done_valid && cyc == done_cyc + 2) begin
            chk("gap_fetch", fifo_rd, idle_ne);
            done_valid = 1'b0;
         end
         if (fifo_rd) begin
            rd_cyc   = cyc;
            rd_valid = 1'b1;
         end
      end
   end

   // Stimulus
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] b);
      fifo_mem[pushed % 256] = b;
      pushed++;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (t < 4000 && !(pushed == popped && !busy && !cap)) begin
         step(1);
         t++;
      end
      chk("drain_timeout", t < 4000, 1);
      step(2);
   endtask

   task automatic wait_rd();
      int t;
      t = 0;
      @(negedge clk);
      while (!fifo_rd && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("rd_seen", fifo_rd, 1);
   endtask

   initial begin
      int p0;
      rst = 1'b1;
      step(3);
      chk("rst_tx", tx, 1);
      chk("rst_busy", busy, 0);
      chk("rst_fifo_rd", fifo_rd, 0);
      chk("rst_frame_done", frame_done, 0);
      rst = 1'b0;

      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         chk("idle_quiet", {fifo_rd, tx, busy}, 3'b010);
      end

      p0 = popped;
      push(8'hA5);
      drain();
      chk("a5_reads", popped - p0, 1);

      p0 = popped;
      push(8'hA5);
      push(8'h07);
      drain();
      chk("b2b_reads", popped - p0, 2);

      // Reset during the third data bit of 0x3C
      p0 = popped;
      push(8'h3C);
      push(8'h5A);
      wait_rd();
      repeat (14) @(posedge clk);
      #1 rst = 1'b1;
      step(1);
      rst = 1'b0;
      @(negedge clk);
      chk("abort_tx", tx, 1);
      chk("abort_busy", busy, 0);
      drain();
      chk("abort_reads", popped - p0, 2);

      // Reset while in FETCH: the read still happens, the word is dropped
      p0 = popped;
      push(8'h11);
      push(8'h22);
      step(1);
      chk("fetch_rd", fifo_rd, 1);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      drain();
      chk("fetch_rst_reads", popped - p0, 2);

      // fifo_empty toggling during a frame of 0xFF
      p0 = popped;
      push(8'hFF);
      wait_rd();
      step(2);
      tog_en = 1'b1;
      for (int i = 0; i < 30; i++) begin
         tog_val = ~tog_val;
         step(1);
      end
      tog_en = 1'b0;
      drain();
      chk("toggle_reads", popped - p0, 1);

      for (int i = 0; i < 15; i++) begin
         int n;
         n = $urandom_range(1, 3);
         for (int j = 0; j < n; j++) push(8'($urandom_range(0, 255)));
         step($urandom_range(0, 60));
      end
      drain();
      chk("all_frames", (exp_rd > drop_to) ? exp_rd : drop_to, exp_wr);
      chk("all_read", popped, pushed);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter WIDTH, default 8: data bits per frame, and the width of fifo_dout.
REQ-002 Parameter CLKS_PER_BIT, default 16: clock cycles per serial bit; legal range 2 or more.
REQ-003 clk  input  1  clock; all logic on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 fifo_empty  input  1  upstream FIFO empty flag.
REQ-006 fifo_dout  input  WIDTH  upstream FIFO read data; valid one cycle after a fifo_rd pulse.
REQ-007 fifo_rd  output  1  read strobe to the upstream FIFO; registered.
REQ-008 tx  output  1  serial line; idle high; registered.
REQ-009 busy  output  1  high whenever the state is not IDLE.
REQ-010 frame_done  output  1  one-cycle pulse on the last cycle of STOP.

Function
REQ-011 States SHALL be IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
REQ-012 IDLE: when fifo_empty=0 is sampled, SHALL go to FETCH; otherwise SHALL stay in IDLE with tx=1.
REQ-013 FETCH SHALL last exactly 1 cycle, with fifo_rd=1; fifo_rd SHALL be 0 in every other state.
REQ-014 LOAD SHALL last 1 cycle; at its closing edge, shift register <= fifo_dout.
REQ-015 Integration contract: a fifo_rd pulse is issued only while fifo_empty=0, and the upstream FIFO honours it; the block performs no read-accept check.
REQ-016 START: tx=0 for CLKS_PER_BIT cycles.
REQ-017 DATA: WIDTH bits, LSB first, each held CLKS_PER_BIT cycles; bit counter 0..WIDTH-1, then exit.
REQ-018 PARITY, present only per REQ-030: tx=even parity (XOR of data bits) for CLKS_PER_BIT cycles.
REQ-019 STOP: tx=1 for CLKS_PER_BIT cycles; frame_done=1 on its final cycle; then go to IDLE.
REQ-020 Baud counter: counts 0..CLKS_PER_BIT-1 in START/DATA/PARITY/STOP; clears on every bit boundary and on state entry.
REQ-021 Frame latency from IDLE exit: 2 + (2+WIDTH+P)*CLKS_PER_BIT cycles, where P=1 if parity is compiled in, else 0.
REQ-022 Back-to-back frames: at least one IDLE cycle between frames; the next FETCH follows that IDLE cycle if fifo_empty=0.
REQ-023 fifo_empty changes during START..STOP SHALL NOT affect the frame in progress.
REQ-024 tx SHALL be glitch-free: it changes only on bit boundaries or on reset.
REQ-025 Bit and baud counters SHALL be sized with $clog2 and SHALL NOT wrap mid-bit.

Reset
REQ-026 When rst=1 at a clock edge, the next state SHALL be IDLE, with tx=1, fifo_rd=0, busy=0, frame_done=0, and counters and shift register at 0.
REQ-027 Reset mid-frame SHALL abort the frame; tx returns high on the cycle after the reset edge; the fetched byte is discarded and not replayed.
REQ-028 Reset during FETCH: the FIFO read still occurs, and the byte is dropped.
REQ-029 rst SHALL take priority over all state transitions.

Configuration
REQ-030 Macro UART_PARITY_EN:
- Defined: PARITY state included, even parity bit sent between the last data bit and STOP.
- Undefined: PARITY state and logic absent; DATA goes directly to STOP.

Verification (WIDTH=8, CLKS_PER_BIT=4)
REQ-031 FIFO holds 0xA5, no parity -> one fifo_rd pulse; tx = 0,1,0,1,0,0,1,0,1,1, each bit for 4 cycles; frame_done 42 cycles after IDLE exit.
REQ-032 UART_PARITY_EN, bytes 0xA5 then 0x07 -> parity bits 0 then 1; 46 cycles per frame; exactly one IDLE cycle between frames.
REQ-033 fifo_empty=1 for 100 cycles -> fifo_rd stays 0, tx stays 1, busy stays 0.
REQ-034 rst pulsed on the 3rd DATA bit of 0x3C -> tx=1 and busy=0 on the next cycle; with the FIFO still non-empty, the next frame carries the next FIFO byte, not 0x3C.
REQ-035 fifo_empty toggled every cycle during a frame of 0xFF -> frame unchanged; no extra fifo_rd pulses.
